uart_receiver: RTL and testbench

Serial-to-parallel UART receiver: the downstream stage of `uart_transmitter`, consuming its `o_TX` line. It recovers 8N1 frames (start bit, 8 data bits LSB-first, 1 stop bit) from an asynchronous serial input using a baud counter and mid-bit sampling. Each good byte is presented as a parallel word with a one-cycle valid strobe; a bad stop bit raises a one-cycle frame-error strobe instead.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_receiver.sv | 142 ++++++++++++++
 tb/tb_uart_receiver.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, stop-bit level
// and a 2-of-3 vote used by the oversampling receiver build.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic UART_STOP_BIT = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input that idles high.
// Both stages reset to 1 so a reset never looks like a falling edge.
module uart_rx_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling driven by a baud counter, one-cycle
// valid strobe for a good byte, one-cycle frame-error strobe for a low stop bit.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a
// 2-of-3 vote over three consecutive samples centred on mid-bit, which moves
// all decisions (and both strobes) one cycle later.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       i_RX,
  output logic [UART_DATA_WIDTH-1:0] o_DATA_OUT,
  output logic                       o_RX_VALID,
  output logic                       o_FRAME_ERROR,
  output logic                       o_RX_BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2);
`else
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif

  logic                       rxSync;
  logic                       rx_q;
  logic                       sampleBit;
  uart_state_e                state_q;
  logic [CNT_W-1:0]           baudCnt_q;
  logic [2:0]                 bitCnt_q;
  logic [UART_DATA_WIDTH-1:0] shift_q;
  logic [UART_DATA_WIDTH-1:0] data_q;
  logic                       valid_q;
  logic                       frameErr_q;
  logic                       busy_q;

  uart_rx_sync u_sync (
    .clk_i   (i_CLK),
    .reset_i (i_RESET),
    .async_i (i_RX),
    .sync_o  (rxSync)
  );

`ifdef UART_RX_MAJORITY_EN
  logic rxPrev_q;

  // Keep one more synchronized sample so the vote sees three in a row
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      rxPrev_q <= 1'b1;
    end else begin
      rxPrev_q <= rx_q;
    end
  end

  assign sampleBit = majority3(rxPrev_q, rx_q, rxSync);
`else
  assign sampleBit = rxSync;
`endif

  // Frame FSM with baud/bit counters, shift register and registered outputs
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      rx_q       <= 1'b1;
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_q       <= rxSync;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_q && !rxSync) begin
            baudCnt_q <= '0;
            state_q   <= START;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (baudCnt_q == START_LAST) begin
            baudCnt_q <= '0;
            if (!sampleBit) begin
              bitCnt_q <= '0;
              state_q  <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baudCnt_q == BIT_LAST) begin
            baudCnt_q <= '0;
            shift_q   <= {sampleBit, shift_q[UART_DATA_WIDTH-1:1]};
            bitCnt_q  <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baudCnt_q == BIT_LAST) begin
            baudCnt_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            if (sampleBit == UART_STOP_BIT) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_DATA_OUT    = data_q;
  assign o_RX_VALID    = valid_q;
  assign o_FRAME_ERROR = frameErr_q;
  assign o_RX_BUSY     = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at CLKS_PER_BIT=16. The serial line is
// built cycle by cycle in a queue; a reference model decodes that line from the
// frame timing rules (start edge, mid-bit sample points, optional 2-of-3 vote)
// and predicts every strobe, its cycle and the data presented with it.
module tb_uart_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] dataOut;
  logic       rxValid;
  logic       frameErr;
  logic       rxBusy;

  typedef struct {
    int         cyc;
    bit         isErr;
    logic [7:0] data;
  } event_t;

  bit     lineQ[$];
  event_t expQ[$];
  event_t obsQ[$];

  int         testsRun = 0;
  int         testsFailed = 0;
  int         busyCycles;
  int         strobeClash;
  logic [7:0] lastGood;
  logic [7:0] snapData;
  logic       snapValid;
  logic       snapErr;
  logic       snapBusy;

  // Free-running system clock
  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_CLK         (clk),
    .i_RESET       (rst),
    .i_RX          (rx),
    .o_DATA_OUT    (dataOut),
    .o_RX_VALID    (rxValid),
    .o_FRAME_ERROR (frameErr),
    .o_RX_BUSY     (rxBusy)
  );

  task automatic appendIdle(input int n);
    for (int i = 0; i < n; i++) lineQ.push_back(1'b1);
  endtask

  task automatic appendFrame(input logic [7:0] b, input bit stopLvl);
    for (int i = 0; i < CPB; i++) lineQ.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) lineQ.push_back(b[k]);
    for (int i = 0; i < CPB; i++) lineQ.push_back(stopLvl);
  endtask

  function automatic bit lineAt(input int j);
    if (j < 0) return 1'b1;
    if (j >= lineQ.size()) return lineQ[lineQ.size()-1];
    return lineQ[j];
  endfunction

  // Value the receiver decides for a bit whose mid-point is line index d
  function automatic bit sampleAt(input int d);
    int ones;
    if (LAT == 0) return lineAt(d);
    ones = int'(lineAt(d-1)) + int'(lineAt(d)) + int'(lineAt(d+1));
    return ones >= 2;
  endfunction

  // Predict strobes: E is the index where the line first reads low after high;
  // bit decisions are at mid-points, the decision edge is two later (sync delay).
  task automatic buildModel(input int resetAt);
    int         j;
    int         e;
    int         x;
    bit         prev;
    bit         stopBit;
    logic [7:0] b;
    logic [7:0] good;
    event_t     ev;
    expQ.delete();
    good = lastGood;
    j = 0;
    prev = 1'b1;
    while (j < lineQ.size()) begin
      if (prev && !lineQ[j]) begin
        e = j;
        if (sampleAt(e + CPB/2)) x = e + CPB/2 + 2 + LAT;
        else x = e + CPB/2 + 9*CPB + 2 + LAT;
        if (resetAt >= 0 && e <= resetAt && x > resetAt) begin
          good = 8'h00;
          j = resetAt + 1;
          prev = 1'b1;
          continue;
        end
        if (!sampleAt(e + CPB/2)) begin
          for (int k = 0; k < 8; k++) b[k] = sampleAt(e + CPB/2 + (k+1)*CPB);
          stopBit = sampleAt(e + CPB/2 + 9*CPB);
          if (stopBit) good = b;
          ev.cyc = x;
          ev.isErr = !stopBit;
          ev.data = good;
          expQ.push_back(ev);
        end
        prev = lineAt(x - 2);
        j = x - 1;
      end else begin
        prev = lineQ[j];
        j++;
      end
    end
  endtask

  // Drive the line queue one entry per clock and record what the DUT reports
  task automatic runLine(input int resetAt);
    bit     prevStrobe;
    event_t ev;
    prevStrobe = 1'b0;
    obsQ.delete();
    busyCycles = 0;
    strobeClash = 0;
    for (int j = 0; j < lineQ.size(); j++) begin
      rx = lineQ[j];
      rst = (j == resetAt);
      @(posedge clk);
      #1;
      if (j == resetAt) begin
        snapData = dataOut;
        snapValid = rxValid;
        snapErr = frameErr;
        snapBusy = rxBusy;
      end
      if (rxValid || frameErr) begin
        ev.cyc = j;
        ev.isErr = frameErr;
        ev.data = dataOut;
        obsQ.push_back(ev);
        if (prevStrobe || (rxValid && frameErr)) strobeClash++;
      end
      prevStrobe = rxValid || frameErr;
      if (rxBusy) busyCycles++;
    end
    rst = 1'b0;
  endtask

  task automatic updateGood();
    foreach (expQ[i]) if (!expQ[i].isErr) lastGood = expQ[i].data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (dataOut !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %h want 00", dataOut); end
    testsRun++;
    if (rxValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b want 0", rxValid); end
    testsRun++;
    if (frameErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ferr: got %b want 0", frameErr); end
    testsRun++;
    if (rxBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", rxBusy); end
    rst = 1'b0;
    lastGood = 8'h00;
  endtask

  task automatic test_single_frame();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lineQ.delete();
    appendIdle(5);
    appendFrame(8'hA5, 1'b1);
    appendIdle(20);
    runLine(-1);
    testsRun++;
    if (obsQ.size() != 1) begin
      testsFailed++;
      $display("[TB] FAIL single_count: got %0d strobes want 1", obsQ.size());
    end else begin
      testsRun++;
      if (obsQ[0].cyc != 5 + 154 + LAT || obsQ[0].isErr || obsQ[0].data !== 8'hA5) begin
        testsFailed++;
        $display("[TB] FAIL single_frame: got cyc %0d err %0b data %h want cyc %0d err 0 data a5",
                 obsQ[0].cyc, obsQ[0].isErr, obsQ[0].data, 5 + 154 + LAT);
      end
    end
    lastGood = 8'hA5;
  endtask

  task automatic test_random_frames();
    lineQ.delete();
    appendIdle(3);
    for (int n = 0; n < 5; n++) begin
      appendFrame(8'($urandom), 1'b1);
      appendIdle($urandom_range(0, 6));
    end
    appendIdle(20);
    buildModel(-1);
    runLine(-1);
    testsRun++;
    if (obsQ.size() != expQ.size()) begin
      testsFailed++;
      $display("[TB] FAIL random_count: got %0d strobes want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (obsQ[i].cyc != expQ[i].cyc || obsQ[i].isErr != expQ[i].isErr || obsQ[i].data !== expQ[i].data) begin
        testsFailed++;
        $display("[TB] FAIL random_event%0d: got cyc %0d err %0b data %h want cyc %0d err %0b data %h",
                 i, obsQ[i].cyc, obsQ[i].isErr, obsQ[i].data, expQ[i].cyc, expQ[i].isErr, expQ[i].data);
      end
    end
    testsRun++;
    if (strobeClash != 0) begin testsFailed++; $display("[TB] FAIL random_clash: got %0d want 0", strobeClash); end
    updateGood();
  endtask

  task automatic test_back_to_back();
    lineQ.delete();
    appendIdle(3);
    appendFrame(8'h3E, 1'b1);
    appendFrame(8'h80, 1'b1);
    appendIdle(20);
    buildModel(-1);
    runLine(-1);
    testsRun++;
    if (obsQ.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got %0d strobes want 2", obsQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (obsQ[i].cyc != expQ[i].cyc || obsQ[i].isErr != expQ[i].isErr || obsQ[i].data !== expQ[i].data) begin
        testsFailed++;
        $display("[TB] FAIL b2b_event%0d: got cyc %0d err %0b data %h want cyc %0d err %0b data %h",
                 i, obsQ[i].cyc, obsQ[i].isErr, obsQ[i].data, expQ[i].cyc, expQ[i].isErr, expQ[i].data);
      end
    end
    testsRun++;
    if (strobeClash != 0) begin testsFailed++; $display("[TB] FAIL b2b_clash: got %0d want 0", strobeClash); end
    updateGood();
  endtask

  task automatic test_frame_error();
    int nValid;
    lineQ.delete();
    appendIdle(3);
    appendFrame(8'h55, 1'b0);
    for (int i = 0; i < 200; i++) lineQ.push_back(1'b0);
    appendIdle(20);
    buildModel(-1);
    runLine(-1);
    nValid = 0;
    foreach (obsQ[i]) if (!obsQ[i].isErr) nValid++;
    testsRun++;
    if (obsQ.size() != expQ.size() || nValid != 0) begin
      testsFailed++;
      $display("[TB] FAIL ferr_count: got %0d strobes (%0d valid) want %0d (0 valid)", obsQ.size(), nValid, expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (obsQ[i].cyc != expQ[i].cyc || obsQ[i].isErr != expQ[i].isErr || obsQ[i].data !== expQ[i].data) begin
        testsFailed++;
        $display("[TB] FAIL ferr_event%0d: got cyc %0d err %0b data %h want cyc %0d err %0b data %h",
                 i, obsQ[i].cyc, obsQ[i].isErr, obsQ[i].data, expQ[i].cyc, expQ[i].isErr, expQ[i].data);
      end
    end
    testsRun++;
    if (dataOut !== lastGood) begin testsFailed++; $display("[TB] FAIL ferr_hold: got %h want %h", dataOut, lastGood); end
  endtask

  task automatic test_false_start();
    lineQ.delete();
    appendIdle(10);
    for (int i = 0; i < 4; i++) lineQ.push_back(1'b0);
    appendIdle(40);
    buildModel(-1);
    runLine(-1);
    testsRun++;
    if (obsQ.size() != expQ.size()) begin
      testsFailed++;
      $display("[TB] FAIL false_start_strobes: got %0d want %0d", obsQ.size(), expQ.size());
    end
    testsRun++;
    if (busyCycles != CPB/2 + LAT) begin
      testsFailed++;
      $display("[TB] FAIL false_start_busy: got %0d cycles want %0d", busyCycles, CPB/2 + LAT);
    end
  endtask

  task automatic test_reset_mid_frame();
    int resetAt;
    lineQ.delete();
    appendIdle(5);
    appendFrame(8'hFF, 1'b1);
    appendIdle(20);
    appendFrame(8'h12, 1'b1);
    appendIdle(20);
    resetAt = 5 + CPB/2 + 5*CPB;
    buildModel(resetAt);
    runLine(resetAt);
    testsRun++;
    if (snapData !== 8'h00 || snapValid !== 1'b0 || snapErr !== 1'b0 || snapBusy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: got data %h v %b fe %b busy %b want 00 0 0 0",
               snapData, snapValid, snapErr, snapBusy);
    end
    testsRun++;
    if (obsQ.size() != 1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_count: got %0d strobes want 1", obsQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (obsQ[i].cyc != expQ[i].cyc || obsQ[i].isErr != expQ[i].isErr || obsQ[i].data !== expQ[i].data) begin
        testsFailed++;
        $display("[TB] FAIL midreset_event%0d: got cyc %0d err %0b data %h want cyc %0d err %0b data %h",
                 i, obsQ[i].cyc, obsQ[i].isErr, obsQ[i].data, expQ[i].cyc, expQ[i].isErr, expQ[i].data);
      end
    end
    lastGood = 8'h12;
  endtask

  task automatic test_glitch();
    logic [7:0] want;
    int         idx;
`ifdef UART_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    lineQ.delete();
    appendIdle(5);
    appendFrame(8'h00, 1'b1);
    appendIdle(20);
    idx = 5 + CPB/2 + 4*CPB;
    lineQ[idx] = ~lineQ[idx];
    buildModel(-1);
    runLine(-1);
    testsRun++;
    if (obsQ.size() != 1) begin
      testsFailed++;
      $display("[TB] FAIL glitch_count: got %0d strobes want 1", obsQ.size());
    end else begin
      testsRun++;
      if (obsQ[0].data !== want || obsQ[0].isErr || obsQ[0].cyc != expQ[0].cyc) begin
        testsFailed++;
        $display("[TB] FAIL glitch_data: got data %h err %0b cyc %0d want data %h err 0 cyc %0d",
                 obsQ[0].data, obsQ[0].isErr, obsQ[0].cyc, want, expQ[0].cyc);
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_frame_error();
    test_false_start();
    test_reset_mid_frame();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
